// File: rtl/ifu_fetch_queue.sv
// Fetch stage: credit-based PC issue to in-order instruction memory,
// DEPTH-entry fetch queue toward decode, redirect flush with stale-response drop.
module ifu_fetch_queue #(
  parameter int              XLEN     = 64,
  parameter int              ILEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 64'h8000_0000,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            ifu_valid,
  input  logic            ifu_ready,
  output logic [XLEN-1:0] ifu_pc,
  output logic [ILEN-1:0] ifu_instr,
  output logic [XLEN-1:0] ifu_snxt_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   count;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   drop;
  logic [AW-1:0]   q_head;
  logic [AW-1:0]   q_tail;
  logic [AW-1:0]   t_rd;
  logic [AW-1:0]   t_wr;

  logic [XLEN-1:0] tag    [DEPTH];
  logic [XLEN-1:0] q_pc   [DEPTH];
  logic [ILEN-1:0] q_instr[DEPTH];

  logic [CW:0]     used;
  logic            issue;
  logic            keep;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] rsp_pc;

  assign used  = {1'b0, count} + {1'b0, inflight};

  assign imem_req_valid = !rst && !redirect_en
                        && (used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc;

  assign issue = imem_req_valid && imem_req_ready;
  assign keep  = imem_rsp_valid && (drop == '0);
  assign push  = keep && !redirect_en;
  assign pop   = ifu_valid && ifu_ready && !redirect_en;

  // A zero-latency response arrives before its tag is in the FIFO.
  assign rsp_pc = (inflight == '0) ? pc : tag[t_rd];

  assign ifu_valid   = (count != '0);
  assign ifu_pc      = ifu_valid ? q_pc[q_head] : '0;
  assign ifu_instr   = ifu_valid ? q_instr[q_head] : '0;
  assign ifu_snxt_pc = ifu_valid ? q_pc[q_head] + XLEN'(4) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      drop     <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      t_rd     <= '0;
      t_wr     <= '0;
    end else begin
      if (issue)
        t_wr <= t_wr + AW'(1);
      if (imem_rsp_valid)
        t_rd <= t_rd + AW'(1);
      if (redirect_en) begin
        // Everything still in flight belongs to the old path.
        pc       <= redirect_pc;
        count    <= '0;
        q_head   <= '0;
        q_tail   <= '0;
        inflight <= inflight - CW'(imem_rsp_valid);
        drop     <= inflight - CW'(imem_rsp_valid);
      end else begin
        if (issue)
          pc <= pc + XLEN'(4);
        inflight <= inflight + CW'(issue) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && drop != '0)
          drop <= drop - CW'(1);
        if (push)
          q_tail <= q_tail + AW'(1);
        if (pop)
          q_head <= q_head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && issue)
      tag[t_wr] <= pc;
    if (!rst && push) begin
      q_pc[q_tail]    <= rsp_pc;
      q_instr[q_tail] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Bench for ifu_fetch_queue: in-order memory model with programmable
// latency, expected-PC scoreboard and directed redirect/stall/reset cases.
module tb_ifu_fetch_queue;

  localparam int          XLEN  = 64;
  localparam int          ILEN  = 32;
  localparam int          DEPTH = 4;
  localparam logic [63:0] RPC   = 64'h8000_0000;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            redirect_en = 1'b0;
  logic [XLEN-1:0] redirect_pc = '0;
  logic            imem_req_valid;
  logic            imem_req_ready = 1'b1;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid = 1'b0;
  logic [ILEN-1:0] imem_rsp_data = '0;
  logic            ifu_valid;
  logic            ifu_ready = 1'b1;
  logic [XLEN-1:0] ifu_pc;
  logic [ILEN-1:0] ifu_instr;
  logic [XLEN-1:0] ifu_snxt_pc;

  ifu_fetch_queue #(
    .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(RPC), .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .redirect_en(redirect_en),
    .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .ifu_valid(ifu_valid),
    .ifu_ready(ifu_ready),
    .ifu_pc(ifu_pc),
    .ifu_instr(ifu_instr),
    .ifu_snxt_pc(ifu_snxt_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } mreq_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          lat = 1;
  int          acc_cnt = 0;
  logic [63:0] exp_q[$];
  mreq_t       pend_q[$];

  function automatic logic [31:0] instr_of(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0013;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: record accepted requests, answer in order after lat cycles.
  always @(negedge clk) begin
    if (rst) begin
      pend_q.delete();
      acc_cnt = 0;
    end else if (imem_req_valid && imem_req_ready) begin
      pend_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      acc_cnt++;
    end
  end

  always @(posedge clk) begin
    #2;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    if (!rst && pend_q.size() != 0 && pend_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(pend_q[0].addr);
      void'(pend_q.pop_front());
    end
  end

  // Scoreboard monitor: compare each accepted head to the expected stream.
  logic [63:0] e;
  always @(negedge clk) begin
    if (!rst && !redirect_en && ifu_valid && ifu_ready
        && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ifu_pc !== e || ifu_instr !== instr_of(e)
          || ifu_snxt_pc !== e + 64'd4) begin
        errors++;
        $display("FAIL stream: pc=%h instr=%h snxt=%h required pc=%h instr=%h snxt=%h",
                 ifu_pc, ifu_instr, ifu_snxt_pc, e, instr_of(e), e + 64'd4);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, got, want);
    end
  endtask

  task automatic push_stream(input logic [63:0] base, input int k);
    for (int i = 0; i < k; i++)
      exp_q.push_back(base + 64'(4 * i));
  endtask

  task automatic drain(input string nm, input int limit, output int n);
    n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain timeout: remaining %0d required 0",
               nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_en = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  int n;

  initial begin
    // Reset state and 1-cycle memory streaming.
    repeat (3) tick();
    chk("rst req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst ifu_valid", 64'(ifu_valid), 64'd0);
    chk("rst ifu_pc", ifu_pc, 64'd0);
    chk("rst ifu_instr", 64'(ifu_instr), 64'd0);
    chk("rst snxt", ifu_snxt_pc, 64'd0);
    rst = 1'b0;
    #1;
    chk("first req_valid", 64'(imem_req_valid), 64'd1);
    chk("first req_addr", imem_req_addr, RPC);
    push_stream(RPC, 8);
    drain("stream", 40, n);
    chk("throughput cycles", 64'(n), 64'd10);

    // Decode stall fills credit, head held, then drains in order.
    ifu_ready = 1'b0;
    lat = 1;
    do_reset();
    repeat (5) tick();
    chk("stall head5", ifu_pc, RPC);
    repeat (5) tick();
    chk("stall accepted", 64'(acc_cnt), 64'd4);
    chk("stall req_valid", 64'(imem_req_valid), 64'd0);
    chk("stall ifu_valid", 64'(ifu_valid), 64'd1);
    chk("stall head10", ifu_pc, RPC);
    chk("stall instr", 64'(ifu_instr), 64'(instr_of(RPC)));
    push_stream(RPC, 8);
    ifu_ready = 1'b1;
    drain("stall", 40, n);

    // Redirect with three requests in flight at latency 4.
    lat = 4;
    do_reset();
    n = 0;
    while (pend_q.size() < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("t3 in flight", 64'(pend_q.size()), 64'd3);
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_0100;
    exp_q.delete();
    push_stream(64'h8000_0100, 8);
    #1;
    chk("t3 redirect req_valid", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_en = 1'b0;
    chk("t3 flush", 64'(ifu_valid), 64'd0);
    drain("t3", 60, n);

    // Redirect coinciding with a response and a ready head.
    lat = 1;
    do_reset();
    repeat (6) tick();
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_0200;
    exp_q.delete();
    push_stream(64'h8000_0200, 8);
    @(negedge clk);
    chk("t4 head before", 64'(ifu_valid), 64'd1);
    chk("t4 rsp same cycle", 64'(imem_rsp_valid), 64'd1);
    tick();
    redirect_en = 1'b0;
    chk("t4 flush", 64'(ifu_valid), 64'd0);
    drain("t4", 40, n);

    // Back-to-back redirects: last target wins.
    lat = 2;
    do_reset();
    repeat (6) tick();
    redirect_en = 1'b1;
    redirect_pc = 64'h8000_0100;
    exp_q.delete();
    tick();
    redirect_pc = 64'h8000_0200;
    push_stream(64'h8000_0200, 8);
    tick();
    redirect_en = 1'b0;
    drain("t5", 50, n);

    // Reset asserted mid-stream.
    lat = 1;
    do_reset();
    repeat (6) tick();
    rst = 1'b1;
    #1;
    chk("t6 req_valid in rst", 64'(imem_req_valid), 64'd0);
    tick();
    rst = 1'b0;
    chk("t6 ifu_valid", 64'(ifu_valid), 64'd0);
    chk("t6 ifu_pc", ifu_pc, 64'd0);
    chk("t6 ifu_instr", 64'(ifu_instr), 64'd0);
    chk("t6 snxt", ifu_snxt_pc, 64'd0);
    #1;
    chk("t6 restart addr", imem_req_addr, RPC);
    chk("t6 restart valid", 64'(imem_req_valid), 64'd1);
    push_stream(RPC, 8);
    drain("t6", 40, n);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
